// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver: double-buffered digit data,
// per-digit enable and blink, and a blanking window at the start of each slot.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                cathode,
    output logic                      frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIMIT = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] SLOT_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

    // Active-low a..g segment pattern, bit 6 = a, bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'h0:    seg_decode = 7'h01;
            4'h1:    seg_decode = 7'h4F;
            4'h2:    seg_decode = 7'h12;
            4'h3:    seg_decode = 7'h06;
            4'h4:    seg_decode = 7'h4C;
            4'h5:    seg_decode = 7'h24;
            4'h6:    seg_decode = 7'h20;
            4'h7:    seg_decode = 7'h0F;
            4'h8:    seg_decode = 7'h00;
            4'h9:    seg_decode = 7'h04;
            4'hA:    seg_decode = 7'h08;
            4'hB:    seg_decode = 7'h60;
            4'hC:    seg_decode = 7'h31;
            4'hD:    seg_decode = 7'h42;
            4'hE:    seg_decode = 7'h30;
            default: seg_decode = 7'h38;
        endcase
    endfunction

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           slot_r;
    logic [BW-1:0]           blink_cnt_r;
    logic                    phase_r;
    logic                    pending_r;
    logic [4*NUM_DIGITS-1:0] shadow_value_r;
    logic [NUM_DIGITS-1:0]   shadow_en_r;
    logic [NUM_DIGITS-1:0]   shadow_blink_r;
    logic [4*NUM_DIGITS-1:0] active_value_r;
    logic [NUM_DIGITS-1:0]   active_en_r;
    logic [NUM_DIGITS-1:0]   active_blink_r;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic [3:0]              nibble_s;
    logic                    digit_on_s;
    logic                    blink_on_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [NUM_DIGITS-1:0]   anode_s;
    logic [6:0]              cathode_s;

    // Slot and frame boundary detection.
    always_comb begin
        slot_end_s  = (presc_r == PRESC_LAST);
        frame_end_s = slot_end_s && (slot_r == SLOT_LAST);
    end

    // Select the current digit's data and form the next pin pattern.
    always_comb begin
        nibble_s   = 4'h0;
        digit_on_s = 1'b0;
        blink_on_s = 1'b0;
        onehot_s   = {NUM_DIGITS{1'b0}};
        anode_s    = {NUM_DIGITS{1'b1}};
        cathode_s  = 7'h7F;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (slot_r == IW'(k)) begin
                nibble_s    = active_value_r[4*k +: 4];
                digit_on_s  = active_en_r[k];
                blink_on_s  = active_blink_r[k];
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
        end
        // The blank window keeps the previous digit's charge from ghosting onto the next anode.
        if ((presc_r >= BLANK_LIMIT) && digit_on_s && !(blink_on_s && phase_r)) begin
            anode_s   = ~onehot_s;
            cathode_s = seg_decode(nibble_s);
        end else begin
            anode_s   = {NUM_DIGITS{1'b1}};
            cathode_s = 7'h7F;
        end
    end

    // Prescaler and slot index.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
            slot_r  <= {IW{1'b0}};
        end else if (slot_end_s) begin
            presc_r <= {PW{1'b0}};
            if (slot_r == SLOT_LAST) begin
                slot_r <= {IW{1'b0}};
            end else begin
                slot_r <= slot_r + IW'(1);
            end
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Blink frame counter and phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_r <= {BW{1'b0}};
            phase_r     <= 1'b0;
        end else if (frame_end_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= {BW{1'b0}};
                phase_r     <= ~phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1);
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // Shadow capture and frame-aligned transfer; the transfer reads the pre-load shadow.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r      <= 1'b0;
            shadow_value_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_en_r    <= {NUM_DIGITS{1'b0}};
            shadow_blink_r <= {NUM_DIGITS{1'b0}};
            active_value_r <= {(4*NUM_DIGITS){1'b0}};
            active_en_r    <= {NUM_DIGITS{1'b0}};
            active_blink_r <= {NUM_DIGITS{1'b0}};
        end else begin
            if (frame_end_s && pending_r) begin
                active_value_r <= shadow_value_r;
                active_en_r    <= shadow_en_r;
                active_blink_r <= shadow_blink_r;
            end else begin
                active_value_r <= active_value_r;
            end
            if (load) begin
                shadow_value_r <= value;
                shadow_en_r    <= digit_en;
                shadow_blink_r <= blink_en;
                pending_r      <= 1'b1;
            end else if (frame_end_s) begin
                pending_r      <= 1'b0;
            end else begin
                pending_r      <= pending_r;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clock) begin
        if (reset) begin
            anode      <= {NUM_DIGITS{1'b1}};
            cathode    <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            anode      <= anode_s;
            cathode    <= cathode_s;
            frame_done <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-count based reference model checked every
// cycle, plus hand-computed pin values at chosen points of each scenario.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = DIV * ND;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  blink_en;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        frame_done;

    int checks = 0;
    int passed = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF)
    ) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .digit_en(digit_en), .blink_en(blink_en),
        .anode(anode), .cathode(cathode), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the scan follows from the number of clocks since reset.
    int          n;
    int          presc, slot, phase;
    bit          model_valid = 1'b0;
    logic [15:0] m_sh_v, m_ac_v;
    logic [3:0]  m_sh_en, m_ac_en, m_sh_bl, m_ac_bl;
    logic        m_pending;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_cathode;
    logic        exp_fd;

    always @(posedge clock) begin
        if (reset) begin
            n = 0; model_valid = 1'b1; m_pending = 1'b0;
            m_sh_v = 16'h0; m_ac_v = 16'h0;
            m_sh_en = 4'h0; m_ac_en = 4'h0; m_sh_bl = 4'h0; m_ac_bl = 4'h0;
            exp_anode = 4'hF; exp_cathode = 7'h7F; exp_fd = 1'b0;
        end else begin
            presc = n % DIV;
            slot  = (n / DIV) % ND;
            phase = ((n / FRAME) / BF) % 2;
            exp_anode = 4'hF; exp_cathode = 7'h7F;
            if (presc >= BLANK && m_ac_en[slot] && !(m_ac_bl[slot] && phase == 1)) begin
                exp_anode[slot] = 1'b0;
                exp_cathode = seg_tab[(m_ac_v >> (4 * slot)) & 16'hF];
            end
            exp_fd = ((n + 1) % FRAME) == 0;
            if (exp_fd && m_pending) begin
                m_ac_v = m_sh_v; m_ac_en = m_sh_en; m_ac_bl = m_sh_bl; m_pending = 1'b0;
            end
            if (load) begin
                m_sh_v = value; m_sh_en = digit_en; m_sh_bl = blink_en; m_pending = 1'b1;
            end
            n++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (model_valid) begin
            check("model_anode", anode, exp_anode);
            check("model_cathode", cathode, exp_cathode);
            check("model_frame_done", frame_done, exp_fd);
            check("one_anode_max", ($countones(~anode) <= 1), 1);
        end
    end

    task automatic wait_fd();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) break;
        end
        check("frame_done_timeout", frame_done, 1);
    endtask

    // Starting on a frame_done cycle, step one frame and pin digits 0 and 2.
    task automatic frame_pins(input string tag, input logic [3:0] a0, input logic [6:0] c0,
                              input logic [3:0] a2, input logic [6:0] c2);
        for (int m = 1; m <= FRAME; m++) begin
            @(negedge clock);
            if (m == 3) begin
                check({tag, "_d0_anode"}, anode, a0);
                check({tag, "_d0_cathode"}, cathode, c0);
            end else if (m == 19) begin
                check({tag, "_d2_anode"}, anode, a2);
                check({tag, "_d2_cathode"}, cathode, c2);
            end else if (m == FRAME) begin
                check({tag, "_frame_done"}, frame_done, 1);
            end
        end
    endtask

    logic [3:0] t2_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] t2_ca [4] = '{7'h38, 7'h08, 7'h12, 7'h4F};

    initial begin
        reset = 1'b1; load = 1'b0; value = 16'h0; digit_en = 4'h0; blink_en = 4'h0;
        repeat (3) @(negedge clock);
        check("reset_anode", anode, 4'hF);
        check("reset_cathode", cathode, 7'h7F);
        check("reset_frame_done", frame_done, 0);
        reset = 1'b0;

        // Idle scan: dark, frame_done every 32 cycles.
        for (int m = 1; m <= 2 * FRAME; m++) begin
            @(negedge clock);
            if (m == 5) check("idle_anode", anode, 4'hF);
            if (m == 31) check("idle_fd_low", frame_done, 0);
            if (m == 32 || m == 64) check("idle_fd_pulse", frame_done, 1);
            if (m == 33) check("idle_fd_one_cycle", frame_done, 0);
        end

        // Load 12AF, shown from the next frame.
        value = 16'h12AF; digit_en = 4'hF; blink_en = 4'h0; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_fd();
        for (int m = 1; m <= FRAME; m++) begin
            @(negedge clock);
            if (m % 8 == 3) begin
                check("t2_anode", anode, t2_an[m / 8]);
                check("t2_cathode", cathode, t2_ca[m / 8]);
            end else if (m % 8 == 2) begin
                check("t2_blank", anode, 4'hF);
            end else if (m == FRAME) begin
                check("t2_frame_done", frame_done, 1);
            end
        end

        // Mid-frame load: current frame keeps the old digits.
        for (int m = 1; m <= FRAME; m++) begin
            @(negedge clock);
            if (m == 10) begin
                value = 16'h0000; load = 1'b1;
            end
            if (m == 11) begin
                check("t3_old_anode", anode, 4'hD);
                check("t3_old_cathode", cathode, 7'h08);
                load = 1'b0;
            end
        end
        frame_pins("t3", 4'hE, 7'h01, 4'hB, 7'h01);

        // Load A mid-frame, then B on the boundary cycle.
        for (int m = 1; m <= FRAME; m++) begin
            @(negedge clock);
            if (m == 10) begin value = 16'h3456; load = 1'b1; end
            if (m == 11) load = 1'b0;
            if (m == 31) begin value = 16'h789A; load = 1'b1; end
            if (m == 32) load = 1'b0;
        end
        frame_pins("t4a", 4'hE, 7'h20, 4'hB, 7'h4C);
        frame_pins("t4b", 4'hE, 7'h08, 4'hB, 7'h00);

        // Enable and blink masks from a fresh reset so the blink phase is known.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        value = 16'h0505; digit_en = 4'b0101; blink_en = 4'b0001; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_fd();
        frame_pins("t5f1", 4'hE, 7'h24, 4'hB, 7'h24);
        frame_pins("t5f2", 4'hF, 7'h7F, 4'hB, 7'h24);
        frame_pins("t5f3", 4'hF, 7'h7F, 4'hB, 7'h24);
        frame_pins("t5f4", 4'hE, 7'h24, 4'hB, 7'h24);

        // Reset while digit 2 is lit.
        for (int m = 1; m <= 19; m++) @(negedge clock);
        check("t6_lit_anode", anode, 4'hB);
        reset = 1'b1;
        @(negedge clock);
        check("t6_dark_anode", anode, 4'hF);
        check("t6_dark_cathode", cathode, 7'h7F);
        check("t6_dark_fd", frame_done, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int m = 1; m <= 33; m++) begin
            @(negedge clock);
            if (m == 3) check("t6_restart_blank", anode, 4'hF);
            if (m == 31) check("t6_fd_low", frame_done, 0);
            if (m == 32) check("t6_fd_pulse", frame_done, 1);
            if (m == 33) check("t6_fd_after", frame_done, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
